// File: rtl/vl_elem_sequencer_pkg.sv
// Shared constants for the vector element sequencer: vtype field layout,
// SEW/LMUL encodings, FSM state encoding and the elements-per-register helper.
package vl_elem_sequencer_pkg;

  localparam int VLEN_DEFAULT    = 64;
  localparam int VL_W            = 7;
  localparam int REG_W           = 5;
  localparam int SEW_W           = 3;
  localparam int LMUL_W          = 3;
  localparam int VTYPE_VALID_BIT = 6;
  localparam int VTYPE_SEW_LSB   = 3;
  localparam int VTYPE_LMUL_LSB  = 0;

  typedef enum logic [SEW_W-1:0] {
    SEW_8  = 3'b000,
    SEW_16 = 3'b001,
    SEW_32 = 3'b010,
    SEW_64 = 3'b011
  } sew_e;

  typedef enum logic [LMUL_W-1:0] {
    LMUL_X1 = 3'b000,
    LMUL_X2 = 3'b001,
    LMUL_X4 = 3'b010,
    LMUL_X8 = 3'b011
  } lmul_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Reserved SEW codes would yield zero elements per register and never finish;
  // clamp to one so the walk always advances.
  function automatic logic [15:0] elems_per_reg(input logic [SEW_W-1:0] sew,
                                                input int bytes_per_beat);
    int e;
    e = bytes_per_beat >> sew;
    if (e < 1) e = 1;
    return e[15:0];
  endfunction

endpackage

// File: rtl/vl_elem_sequencer_if.sv
// Issue and beat handshake bundle between ID (master) and the sequencer (slave).
interface vl_elem_sequencer_if #(
  parameter int VLEN = 64
);
  logic              start;
  logic              start_ready;
  logic [4:0]        vd;
  logic [4:0]        vs1;
  logic [4:0]        vs2;
  logic              beat_valid;
  logic              beat_ready;
  logic [4:0]        beat_vd;
  logic [4:0]        beat_vs1;
  logic [4:0]        beat_vs2;
  logic [6:0]        beat_elem_idx;
  logic [VLEN/8-1:0] beat_byte_mask;
  logic              beat_last;

  modport master (
    output start, vd, vs1, vs2, beat_ready,
    input  start_ready, beat_valid, beat_vd, beat_vs1, beat_vs2,
           beat_elem_idx, beat_byte_mask, beat_last
  );

  modport slave (
    input  start, vd, vs1, vs2, beat_ready,
    output start_ready, beat_valid, beat_vd, beat_vs1, beat_vs2,
           beat_elem_idx, beat_byte_mask, beat_last
  );
endinterface

// File: rtl/vl_elem_sequencer_mask_gen.sv
// Tail byte-mask generator: low min(VLEN/8, (vl - elem_idx) << SEW) bits set.
module vseq_mask_gen
  import vl_elem_sequencer_pkg::*;
#(
  parameter int VLEN = VLEN_DEFAULT
) (
  input  logic [VL_W-1:0]   vl,
  input  logic [VL_W-1:0]   elem_idx,
  input  logic [SEW_W-1:0]  sew,
  output logic [VLEN/8-1:0] mask
);
  localparam int BPB = VLEN / 8;

  logic [VL_W-1:0] remaining;
  logic [15:0]     active_bytes;

  always_comb begin
    remaining    = (vl > elem_idx) ? (vl - elem_idx) : '0;
    active_bytes = {{(16 - VL_W){1'b0}}, remaining} << sew;
    if (active_bytes > 16'(BPB)) active_bytes = 16'(BPB);
  end

  generate
    for (genvar gi = 0; gi < BPB; gi++) begin : g_mask
      assign mask[gi] = (16'(gi) < active_bytes);
    end
  endgenerate

endmodule

// File: rtl/vl_elem_sequencer.sv
// Holds vl/vtype CSRs and walks each issued instruction one register per beat.
// Build option: VSEQ_TAIL_MASK_EN enables the tail byte mask (otherwise all ones).
module vl_elem_sequencer
  import vl_elem_sequencer_pkg::*;
#(
  parameter int VLEN = VLEN_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              csr_wen,
  input  logic [VL_W-1:0]   csr_vl,
  input  logic [6:0]        csr_vtype,
  vl_elem_sequencer_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              vill
);
  localparam int BPB = VLEN / 8;

  logic [VL_W-1:0]  vl_q;
  logic [6:0]       vtype_q;
  state_t           state;

  logic [VL_W-1:0]  vl_w;
  logic [SEW_W-1:0] sew_w;
  logic [REG_W-1:0] vd_w, vs1_w, vs2_w;
  logic [REG_W-1:0] beat_cnt;
  logic [VL_W-1:0]  elem_idx;

  logic             start_ready_reg, beat_valid_reg, beat_last_reg;
  logic             busy_reg, done_reg, err_reg;
  logic [REG_W-1:0] beat_vd_reg, beat_vs1_reg, beat_vs2_reg;
  logic [BPB-1:0]   beat_mask_reg;

  logic [VL_W-1:0]  nxt_vl, nxt_idx;
  logic [SEW_W-1:0] nxt_sew;
  logic [REG_W-1:0] nxt_cnt, nxt_vd, nxt_vs1, nxt_vs2;
  logic [15:0]      cur_epr, nxt_epr;
  logic             nxt_last;
  logic [BPB-1:0]   nxt_mask;
  logic             accept, load_beat;
  logic             lmul_unused;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vl_q    <= '0;
      vtype_q <= '0;
    end else if (csr_wen) begin
      vl_q    <= csr_vl;
      vtype_q <= csr_vtype;
    end
  end

  assign vill = ~vtype_q[VTYPE_VALID_BIT];
  // LMUL only bounds vl upstream; the walk itself terminates on vl.
  assign lmul_unused = ^vtype_q[VTYPE_LMUL_LSB +: LMUL_W];

  assign cur_epr = elems_per_reg(sew_w, BPB);

  // Fields of the beat about to be launched: first beat from CSRs in IDLE,
  // otherwise the successor of the beat currently presented.
  always_comb begin
    nxt_vl  = vl_w;
    nxt_sew = sew_w;
    nxt_idx = elem_idx + cur_epr[VL_W-1:0];
    nxt_cnt = beat_cnt + 1'b1;
    nxt_vd  = vd_w;
    nxt_vs1 = vs1_w;
    nxt_vs2 = vs2_w;
    if (state == ST_IDLE) begin
      nxt_vl  = vl_q;
      nxt_sew = vtype_q[VTYPE_SEW_LSB +: SEW_W];
      nxt_idx = '0;
      nxt_cnt = '0;
      nxt_vd  = bus.vd;
      nxt_vs1 = bus.vs1;
      nxt_vs2 = bus.vs2;
    end
  end

  assign nxt_epr  = elems_per_reg(nxt_sew, BPB);
  assign nxt_last = ({{(16 - VL_W){1'b0}}, nxt_idx} + nxt_epr) >= {{(16 - VL_W){1'b0}}, nxt_vl};

`ifdef VSEQ_TAIL_MASK_EN
  vseq_mask_gen #(.VLEN(VLEN)) u_mask_gen (
    .vl       (nxt_vl),
    .elem_idx (nxt_idx),
    .sew      (nxt_sew),
    .mask     (nxt_mask)
  );
`else
  assign nxt_mask = '1;
`endif

  assign accept    = (state == ST_IDLE) && bus.start && start_ready_reg;
  assign load_beat = (accept && vtype_q[VTYPE_VALID_BIT] && (vl_q != '0)) ||
                     ((state == ST_RUN) && bus.beat_ready && !beat_last_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      start_ready_reg <= 1'b1;
      beat_valid_reg  <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
      vl_w            <= '0;
      sew_w           <= '0;
      vd_w            <= '0;
      vs1_w           <= '0;
      vs2_w           <= '0;
      beat_cnt        <= '0;
      elem_idx        <= '0;
      beat_vd_reg     <= '0;
      beat_vs1_reg    <= '0;
      beat_vs2_reg    <= '0;
      beat_mask_reg   <= '0;
      beat_last_reg   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            vl_w            <= vl_q;
            sew_w           <= vtype_q[VTYPE_SEW_LSB +: SEW_W];
            vd_w            <= bus.vd;
            vs1_w           <= bus.vs1;
            vs2_w           <= bus.vs2;
            start_ready_reg <= 1'b0;
            if (!vtype_q[VTYPE_VALID_BIT]) begin
              state    <= ST_DONE;
              done_reg <= 1'b1;
              err_reg  <= 1'b1;
            end else if (vl_q == '0) begin
              state    <= ST_DONE;
              done_reg <= 1'b1;
              err_reg  <= 1'b0;
            end else begin
              state          <= ST_RUN;
              busy_reg       <= 1'b1;
              beat_valid_reg <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (bus.beat_ready && beat_last_reg) begin
            state          <= ST_DONE;
            beat_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b1;
            err_reg        <= 1'b0;
          end
        end
        ST_DONE: begin
          state           <= ST_IDLE;
          done_reg        <= 1'b0;
          err_reg         <= 1'b0;
          start_ready_reg <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase

      if (load_beat) begin
        beat_cnt      <= nxt_cnt;
        elem_idx      <= nxt_idx;
        beat_vd_reg   <= nxt_vd + nxt_cnt;
        beat_vs1_reg  <= nxt_vs1 + nxt_cnt;
        beat_vs2_reg  <= nxt_vs2 + nxt_cnt;
        beat_mask_reg <= nxt_mask;
        beat_last_reg <= nxt_last;
      end
    end
  end

  assign bus.start_ready    = start_ready_reg;
  assign bus.beat_valid     = beat_valid_reg;
  assign bus.beat_vd        = beat_vd_reg;
  assign bus.beat_vs1       = beat_vs1_reg;
  assign bus.beat_vs2       = beat_vs2_reg;
  assign bus.beat_elem_idx  = elem_idx;
  assign bus.beat_byte_mask = beat_mask_reg;
  assign bus.beat_last      = beat_last_reg;
  assign busy               = busy_reg;
  assign done               = done_reg;
  assign err                = err_reg;

endmodule
